// File: rtl/pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : pio_in_edge_irq
// Description : Avalon-MM input PIO. Synchronised WIDTH-bit input bus, per-bit
//               edge detection into a write-1-to-clear capture register and a
//               maskable level or edge interrupt. Four-word slave.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_in_edge_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Edge detection stays disabled until the synchroniser and prev register
    // hold post-reset samples, so a pin held high through reset is not seen
    // as a rising edge.
    localparam int                 c_ARM_COUNT = SYNC_STAGES + 1;
    localparam int                 c_ARM_W     = $clog2(c_ARM_COUNT + 1);
    localparam logic [c_ARM_W-1:0] c_ARM_DONE  = c_ARM_W'(c_ARM_COUNT);
    localparam logic [1:0]         c_ADDR_DATA = 2'd0;
    localparam logic [1:0]         c_ADDR_MASK = 2'd2;
    localparam logic [1:0]         c_ADDR_CAPT = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [c_ARM_W-1:0]                r_arm_cnt;
    logic [WIDTH-1:0]                  r_mask;
    logic [WIDTH-1:0]                  r_capture;

    logic [WIDTH-1:0] w_data_s;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge_raw;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_irq_src;
    logic             w_armed;
    logic             w_wr;
    logic             w_mask_we;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    assign w_data_s = r_sync[SYNC_STAGES-1];
    assign w_rise   = w_data_s & ~r_prev;
    assign w_fall   = ~w_data_s & r_prev;

    generate
        if (EDGE_TYPE == 0) begin : g_edge_rise
            assign w_edge_raw = w_rise;
        end else if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge_raw = w_fall;
        end else begin : g_edge_any
            assign w_edge_raw = w_rise | w_fall;
        end
    endgenerate

    assign w_armed = (r_arm_cnt == c_ARM_DONE);
    assign w_edge  = w_armed ? w_edge_raw : '0;

    // Write decode: mask load and write-1-to-clear of capture bits.
    assign w_wr           = chipselect & write;
    assign w_mask_we      = w_wr && (address == c_ADDR_MASK);
    assign w_clr          = (w_wr && (address == c_ADDR_CAPT)) ? writedata[WIDTH-1:0] : '0;
    assign w_unused_wdata = ^writedata;

    generate
        if (IRQ_MODE == 0) begin : g_irq_level
            assign w_irq_src = r_mask & w_data_s;
        end else begin : g_irq_edge
            assign w_irq_src = r_mask & r_capture;
        end
    endgenerate

    // Read mux; unimplemented bits and the reserved word read as zero.
    always_comb begin
        w_rdata = '0;
        case (address)
            c_ADDR_DATA: w_rdata[WIDTH-1:0] = w_data_s;
            c_ADDR_MASK: w_rdata[WIDTH-1:0] = r_mask;
            c_ADDR_CAPT: w_rdata[WIDTH-1:0] = r_capture;
            default:     w_rdata            = '0;
        endcase
    end

    // Input synchroniser chain and one-clock delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev <= w_data_s;
        end
    end

    // Post-reset arming counter; saturates once edges are allowed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arm_cnt <= '0;
        end else if (r_arm_cnt != c_ARM_DONE) begin
            r_arm_cnt <= r_arm_cnt + c_ARM_W'(1);
        end
    end

    // Mask register and edge capture; a new edge beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask    <= '0;
            r_capture <= '0;
        end else begin
            if (w_mask_we) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            r_capture <= (r_capture & ~w_clr) | w_edge;
        end
    end

    // Registered read data and interrupt output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= w_rdata;
            irq      <= |w_irq_src;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pio_in_edge_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_in_edge_irq
// Description : Self-checking bench for pio_in_edge_irq. Four instances cover
//               rising/edge-irq, any-edge, level-irq and a 3-bit width.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_in_edge_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  cs;
    logic [7:0]  in0, in1, in2;
    logic [2:0]  in3;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        irq0, irq1, irq2, irq3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[0]), .write(write),
        .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));
    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MODE(1)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[1]), .write(write),
        .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));
    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)) u_lvl (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[2]), .write(write),
        .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));
    pio_in_edge_irq #(.WIDTH(3), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) u_w3 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs[3]), .write(write),
        .writedata(writedata), .in_port(in3), .readdata(rd3), .irq(irq3));

    // Scoreboard of expected read results
    typedef struct packed {
        logic [1:0]  dut;
        logic [31:0] exp;
    } sb_t;
    sb_t   sbq[$];
    string sbn[$];

    // Register-map vectors for the 3-bit instance
    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[12];

    function automatic logic [31:0] rd_of(input int d);
        case (d)
            0:       return rd0;
            1:       return rd1;
            2:       return rd2;
            default: return rd3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int d, input logic [1:0] a, input logic [31:0] data);
        address   = a;
        writedata = data;
        write     = 1'b1;
        cs        = '0;
        cs[d]     = 1'b1;
        tick();
        write     = 1'b0;
        cs        = '0;
        writedata = '0;
    endtask

    task automatic sb_pop();
        sb_t   e;
        string n;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no entry, expected one");
        end else begin
            e = sbq.pop_front();
            n = sbn.pop_front();
            check(n, rd_of(int'(e.dut)), e.exp);
        end
    endtask

    // Present an address for one clock; expectation queued now, compared once
    // the registered read data is available.
    task automatic bus_read(input string name, input int d, input logic [1:0] a,
                            input logic [31:0] exp);
        sb_t e;
        address = a;
        cs      = '0;
        cs[d]   = 1'b1;
        e.dut   = 2'(d);
        e.exp   = exp;
        sbq.push_back(e);
        sbn.push_back(name);
        tick();
        cs = '0;
        sb_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        address   = '0;
        write     = 1'b0;
        writedata = '0;
        cs        = '0;
        in0       = 8'hFF;
        in1       = 8'h00;
        in2       = 8'h00;
        in3       = 3'b101;

        vt[0]  = '{wr: 1'b0, addr: 2'd0, data: 32'h0,        exp: 32'h0000_0005};
        vt[1]  = '{wr: 1'b0, addr: 2'd1, data: 32'h0,        exp: 32'h0000_0000};
        vt[2]  = '{wr: 1'b0, addr: 2'd2, data: 32'h0,        exp: 32'h0000_0000};
        vt[3]  = '{wr: 1'b0, addr: 2'd3, data: 32'h0,        exp: 32'h0000_0000};
        vt[4]  = '{wr: 1'b1, addr: 2'd0, data: 32'hFFFF_FFFF, exp: 32'h0};
        vt[5]  = '{wr: 1'b0, addr: 2'd0, data: 32'h0,        exp: 32'h0000_0005};
        vt[6]  = '{wr: 1'b1, addr: 2'd1, data: 32'hFFFF_FFFF, exp: 32'h0};
        vt[7]  = '{wr: 1'b0, addr: 2'd1, data: 32'h0,        exp: 32'h0000_0000};
        vt[8]  = '{wr: 1'b1, addr: 2'd2, data: 32'hFFFF_FFFF, exp: 32'h0};
        vt[9]  = '{wr: 1'b0, addr: 2'd2, data: 32'h0,        exp: 32'h0000_0007};
        vt[10] = '{wr: 1'b1, addr: 2'd3, data: 32'hFFFF_FFFF, exp: 32'h0};
        vt[11] = '{wr: 1'b0, addr: 2'd3, data: 32'h0,        exp: 32'h0000_0000};

        // Reset state
        repeat (3) tick();
        check("reset_readdata", rd0, 32'h0);
        check("reset_irq", {31'h0, irq0}, 32'h0);
        check("reset_readdata_w3", rd3, 32'h0);
        reset = 1'b0;

        // Input held high through reset: no false edge, no interrupt
        bus_write(0, 2'd2, 32'h0000_00FF);
        for (int i = 0; i < 20; i++) begin
            bus_read($sformatf("arm_capture_c%0d", i), 0, 2'd3, 32'h0);
            check($sformatf("arm_irq_c%0d", i), {31'h0, irq0}, 32'h0);
        end
        bus_read("arm_data", 0, 2'd0, 32'h0000_00FF);

        // Rising-only: falling edge on bit 0 is not captured
        bus_write(0, 2'd2, 32'h0000_0001);
        in0 = 8'hFE;
        repeat (5) tick();
        bus_read("rise_ignores_fall", 0, 2'd3, 32'h0);

        // Rising edge: capture sets at clock 3, readable and irq at clock 4
        in0 = 8'hFF;
        for (int k = 1; k <= 4; k++) begin
            bus_read($sformatf("rise_capture_k%0d", k), 0, 2'd3, (k == 4) ? 32'h1 : 32'h0);
            check($sformatf("rise_irq_k%0d", k), {31'h0, irq0}, (k == 4) ? 32'h1 : 32'h0);
        end

        // Write-1-to-clear: readdata shows the pre-write value, irq lags a clock
        bus_write(0, 2'd3, 32'h0000_0001);
        check("clr_read_old", rd0, 32'h1);
        check("clr_irq_lag", {31'h0, irq0}, 32'h1);
        bus_read("clr_capture", 0, 2'd3, 32'h0);
        check("clr_irq_low", {31'h0, irq0}, 32'h0);

        // Clear coinciding with a new edge: the set wins
        in0 = 8'hFE;
        repeat (5) tick();
        in0 = 8'hFF;
        tick();
        tick();
        bus_write(0, 2'd3, 32'h0000_0001);
        bus_read("set_wins", 0, 2'd3, 32'h1);
        check("set_wins_irq", {31'h0, irq0}, 32'h1);
        bus_write(0, 2'd3, 32'h0000_0001);
        bus_read("set_wins_cleared", 0, 2'd3, 32'h0);

        // Any-edge with mask 0: rises and falls captured, irq held off
        bus_write(1, 2'd2, 32'h0);
        in1 = 8'h88;
        repeat (6) tick();
        bus_read("any_rise", 1, 2'd3, 32'h88);
        check("any_rise_irq", {31'h0, irq1}, 32'h0);
        bus_write(1, 2'd3, 32'hFFFF_FFFF);
        bus_read("any_clr", 1, 2'd3, 32'h0);
        in1 = 8'h00;
        repeat (6) tick();
        bus_read("any_fall", 1, 2'd3, 32'h88);
        check("any_fall_irq", {31'h0, irq1}, 32'h0);
        bus_write(1, 2'd2, 32'h0000_0008);
        check("any_mask_irq_lag", {31'h0, irq1}, 32'h0);
        tick();
        check("any_mask_irq", {31'h0, irq1}, 32'h1);
        bus_read("any_mask_rd", 1, 2'd2, 32'h8);

        // Level interrupt follows synchronised bit 4
        bus_write(2, 2'd2, 32'h0000_0010);
        in2 = 8'h10;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("lvl_rise_k%0d", k), {31'h0, irq2}, (k == 3) ? 32'h1 : 32'h0);
        end
        repeat (3) tick();
        check("lvl_hold", {31'h0, irq2}, 32'h1);
        in2 = 8'h00;
        tick();
        tick();
        check("lvl_fall_still_high", {31'h0, irq2}, 32'h1);
        tick();
        tick();
        check("lvl_fall_low", {31'h0, irq2}, 32'h0);
        bus_read("lvl_data", 2, 2'd0, 32'h0);

        // 3-bit instance register map
        for (int i = 0; i < 12; i++) begin
            if (vt[i].wr) begin
                bus_write(3, vt[i].addr, vt[i].data);
            end else begin
                bus_read($sformatf("w3_v%0d_a%0d", i, vt[i].addr), 3, vt[i].addr, vt[i].exp);
            end
        end

        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
